// File: rtl/spork_mem_pkg.sv
// spork_mem_pkg: shared widths, data types and controller state encoding for the SPORK DataMemory port.
package spork_mem_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_BEAT,
        RD_ISSUE,
        RD_WAIT,
        RD_HOLD
    } mem_ctrl_state_t;

endpackage

// File: rtl/mem_addr_gen.sv
// mem_addr_gen: burst address/beat counter; latches base and length on load, steps with wrap, flags last beat.
module mem_addr_gen #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] baseAddr,
    input  logic [LEN_W-1:0]  len,
    input  logic              advance,
    output logic [ADDR_W-1:0] curAddr,
    output logic              lastBeat
);

    logic [LEN_W-1:0] beatCnt;
    logic [LEN_W-1:0] lenReg;

    assign lastBeat = beatCnt == lenReg;

    // Address wraps naturally at 2^ADDR_W through the fixed-width add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curAddr <= '0;
            beatCnt <= '0;
            lenReg  <= '0;
        end else if (load) begin
            curAddr <= baseAddr;
            beatCnt <= '0;
            lenReg  <= len;
        end else if (advance) begin
            curAddr <= curAddr + 1'b1;
            beatCnt <= beatCnt + 1'b1;
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: initiator for DataMemory; sequences single/burst loads and stores from the datapath
// with valid/ready on both request and data streams.
module data_mem_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int LEN_W      = 4,
    parameter int MEM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic              busy,
    output logic              ReadMem,
    output logic              WriteMem,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] DataIn,
    input  logic [DATA_W-1:0] DataOut
);

    import spork_mem_pkg::*;

    mem_ctrl_state_t state, nextState;
    logic [ADDR_W-1:0] curAddr;
    logic [ADDR_W-1:0] lastAddr;
    logic              lastBeat;
    logic              accept;
    logic              advance;
    logic              capture;

    assign req_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign accept    = req_valid && req_ready;
    assign wr_ready  = state == WR_BEAT && wr_valid;
    assign WriteMem  = wr_ready;
    assign ReadMem   = state == RD_ISSUE;
    assign rd_valid  = state == RD_HOLD;
    assign advance   = WriteMem || (rd_valid && rd_ready);
    assign capture   = (state == RD_ISSUE && MEM_RD_LAT == 0) || state == RD_WAIT;
    // Strobes see the live burst address; between strobes the bus parks on the last one issued.
    assign data_addr = (WriteMem || ReadMem) ? curAddr : lastAddr;
    assign DataIn    = WriteMem ? wr_data : '0;

    mem_addr_gen #(
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .baseAddr(req_addr),
        .len     (req_len),
        .advance (advance),
        .curAddr (curAddr),
        .lastBeat(lastBeat)
    );

    always_comb begin
        nextState = state;
        case (state)
            IDLE:     nextState = accept ? (req_write ? WR_BEAT : RD_ISSUE) : IDLE;
            WR_BEAT:  nextState = (wr_valid && lastBeat) ? IDLE : WR_BEAT;
            RD_ISSUE: nextState = (MEM_RD_LAT == 0) ? RD_HOLD : RD_WAIT;
            RD_WAIT:  nextState = RD_HOLD;
            RD_HOLD:  nextState = rd_ready ? (lastBeat ? IDLE : RD_ISSUE) : RD_HOLD;
            default:  nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rd_data  <= '0;
            lastAddr <= '0;
        end else begin
            state <= nextState;
            if (capture)
                rd_data <= DataOut;
            if (WriteMem || ReadMem)
                lastAddr <= curAddr;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: drives data_mem_ctrl against a 1-cycle-latency DataMemory model; load data is
// scoreboarded, strobe activity is logged by a negedge monitor.
module tb_data_mem_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [7:0] req_addr = '0;
    logic [3:0] req_len = '0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_ready = 1'b1;
    logic       busy;
    logic       ReadMem;
    logic       WriteMem;
    logic [7:0] data_addr;
    logic [7:0] DataIn;
    logic [7:0] DataOut = '0;

    logic [7:0] mem [256] = '{default: 8'h00};
    logic [7:0] modelMem [256] = '{default: 8'h00};
    logic [7:0] wrBuf [16];
    logic [7:0] expQ [$];
    logic [7:0] actQ [$];
    logic [7:0] wrAddrQ [$];
    int wrCnt = 0;
    int bothCnt = 0;
    int compared = 0;
    int failed = 0;

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
    } vec_t;

    vec_t tbl [10];

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_W(8), .DATA_W(8), .LEN_W(4), .MEM_RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .busy(busy), .ReadMem(ReadMem), .WriteMem(WriteMem),
        .data_addr(data_addr), .DataIn(DataIn), .DataOut(DataOut)
    );

    always @(posedge clk) begin
        if (WriteMem) mem[data_addr] <= DataIn;
        if (ReadMem) DataOut <= mem[data_addr];
    end

    always @(negedge clk) begin
        if (rd_valid && rd_ready) actQ.push_back(rd_data);
        if (WriteMem) begin
            wrCnt++;
            wrAddrQ.push_back(data_addr);
        end
        if (ReadMem && WriteMem) bothCnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 100 && busy; i++) tick();
        if (busy) check("idle timeout", 32'(busy), 0);
    endtask

    task automatic issue(input bit w, input logic [7:0] a, input logic [3:0] len);
        waitIdle();
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_len   = len;
        tick();
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = ~a;
        req_len   = 4'hF;
    endtask

    task automatic doStore(input logic [7:0] a, input int n, input logic [15:0] pat);
        int beat = 0;
        issue(1'b1, a, 4'(n - 1));
        for (int cyc = 0; beat < n && cyc < 64; cyc++) begin
            wr_valid = pat[cyc % 16];
            wr_data  = wrBuf[beat];
            @(posedge clk);
            if (wr_valid) begin
                modelMem[8'(a + beat)] = wr_data;
                beat++;
            end
            #1;
        end
        wr_valid = 1'b0;
        check("store beats done", beat, n);
    endtask

    task automatic doLoad(input logic [7:0] a, input int n);
        int target;
        target = actQ.size() + n;
        rd_ready = 1'b1;
        issue(1'b0, a, 4'(n - 1));
        for (int i = 0; i < 200 && actQ.size() < target; i++) begin
            @(negedge clk);
            #1;
        end
        check("load beats returned", actQ.size(), target);
    endtask

    task automatic drain(input string name);
        while (expQ.size() > 0 && actQ.size() > 0)
            check(name, 32'(actQ.pop_front()), 32'(expQ.pop_front()));
        check({name, " queue balance"}, expQ.size() + actQ.size(), 0);
        expQ.delete();
        actQ.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        logic [7:0] hold;
        tbl = '{
            '{1'b1, 8'h00, 8'h0F}, '{1'b0, 8'h00, 8'h0F},
            '{1'b1, 8'h0C, 8'h04}, '{1'b1, 8'h0C, 8'h06}, '{1'b0, 8'h0C, 8'h06},
            '{1'b1, 8'h55, 8'hAA}, '{1'b0, 8'h55, 8'hAA},
            '{1'b1, 8'hFF, 8'h3C}, '{1'b0, 8'hFF, 8'h3C}, '{1'b0, 8'h00, 8'h0F}
        };

        #1;
        check("reset ReadMem", 32'(ReadMem), 0);
        check("reset WriteMem", 32'(WriteMem), 0);
        check("reset busy", 32'(busy), 0);
        check("reset req_ready", 32'(req_ready), 1);
        check("reset rd_valid", 32'(rd_valid), 0);
        check("reset wr_ready", 32'(wr_ready), 0);
        check("reset rd_data", 32'(rd_data), 0);
        check("reset data_addr", 32'(data_addr), 0);
        check("reset DataIn", 32'(DataIn), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        foreach (tbl[i]) begin
            if (tbl[i].wr) begin
                wrBuf[0] = tbl[i].data;
                w0 = wrCnt;
                doStore(tbl[i].addr, 1, 16'hFFFF);
                check("single store strobe cycles", wrCnt - w0, 1);
            end else begin
                expQ.push_back(tbl[i].data);
                doLoad(tbl[i].addr, 1);
                drain("table load data");
            end
        end

        // Wrapping store burst FE,FF,00 then read back
        wrBuf[0] = 8'hA1; wrBuf[1] = 8'hA2; wrBuf[2] = 8'hA3;
        wrAddrQ.delete();
        doStore(8'hFE, 3, 16'hFFFF);
        check("wrap beats", wrAddrQ.size(), 3);
        check("wrap addr beat0", 32'(wrAddrQ[0]), 32'h0FE);
        check("wrap addr beat1", 32'(wrAddrQ[1]), 32'h0FF);
        check("wrap addr beat2", 32'(wrAddrQ[2]), 32'h000);
        tick();
        check("idle data_addr holds last", 32'(data_addr), 32'h000);
        expQ.push_back(8'hA1); expQ.push_back(8'hA2); expQ.push_back(8'hA3);
        doLoad(8'hFE, 3);
        drain("wrap burst load");

        // Load burst of 4 with a 5-cycle consumer stall on beat 1
        wrBuf[0] = 8'h11; wrBuf[1] = 8'h22; wrBuf[2] = 8'h33; wrBuf[3] = 8'h44;
        doStore(8'h40, 4, 16'hFFFF);
        for (int i = 0; i < 4; i++) expQ.push_back(wrBuf[i]);
        rd_ready = 1'b1;
        issue(1'b0, 8'h40, 4'd3);
        for (int i = 0; i < 50 && actQ.size() < 1; i++) begin
            @(negedge clk);
            #1;
        end
        tick();
        rd_ready = 1'b0;
        for (int i = 0; i < 50 && !rd_valid; i++) tick();
        check("stall beat1 valid", 32'(rd_valid), 1);
        hold = rd_data;
        check("stall beat1 data", 32'(hold), 32'h22);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall rd_data stable", 32'(rd_data), 32'(hold));
            check("stall no ReadMem", 32'(ReadMem), 0);
            check("stall rd_valid held", 32'(rd_valid), 1);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 100 && actQ.size() < 4; i++) begin
            @(negedge clk);
            #1;
        end
        drain("stalled burst load");

        // Store burst with wr_valid gaps 1,0,0,1
        wrBuf[0] = 8'h5A; wrBuf[1] = 8'hC3;
        w0 = wrCnt;
        doStore(8'h80, 2, 16'b1001);
        check("gap store strobe cycles", wrCnt - w0, 2);
        expQ.push_back(8'h5A); expQ.push_back(8'hC3);
        doLoad(8'h80, 2);
        drain("gap store readback");

        // Async reset after beat 0 of a 4-beat store
        wrBuf[0] = 8'h99;
        doStore(8'h21, 1, 16'hFFFF);
        issue(1'b1, 8'h20, 4'd3);
        wr_valid = 1'b1;
        wr_data  = 8'h77;
        tick();
        modelMem[8'h20] = 8'h77;
        wr_data = 8'h78;
        check("pre-reset WriteMem", 32'(WriteMem), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset-mid WriteMem", 32'(WriteMem), 0);
        check("reset-mid ReadMem", 32'(ReadMem), 0);
        check("reset-mid busy", 32'(busy), 0);
        check("reset-mid wr_ready", 32'(wr_ready), 0);
        wr_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post-reset req_ready", 32'(req_ready), 1);
        expQ.push_back(modelMem[8'h20]);
        expQ.push_back(modelMem[8'h21]);
        doLoad(8'h20, 2);
        drain("post-reset memory");

        check("ReadMem&WriteMem overlap cycles", bothCnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
